dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-ported Data_Mem. Port 0 is the
//  pipeline MEM stage; port 1 is the loader/debug requester. Serialises accesses with
//  a req/gnt/done handshake and drives Data_Mem's Mem_Address/Write_Data/
//  Store_Byte_or_Word/Mem_Write/Mem_Read from registers.
//  Port 0 has priority; a starvation counter guarantees port 1 progress.
// PARAMETERS
//  ADDR_W    32  address width to Data_Mem
//  DATA_W    32  data width
//  MAX_WAIT  4   consecutive port-1 losses before port 1 is forced to win (1..15)
// PORTS
//  clk                 in   1       rising-edge clock, the only clock
//  rst                 in   1       asynchronous, active-high reset
//  p0_req, p1_req      in   1       request; hold high with fields stable until done
//  p0_we, p1_we        in   1       1 = write, 0 = read
//  p0_byte, p1_byte    in   1       1 = byte store, 0 = word (only meaningful on writes)
//  p0_addr, p1_addr    in   ADDR_W  byte address
//  p0_wdata, p1_wdata  in   DATA_W  write data
//  p0_gnt, p1_gnt      out  1       port owns memory (ACCESS and RESP states)
//  p0_done, p1_done    out  1       one-cycle completion pulse
//  p0_rdata, p1_rdata  out  DATA_W  last read result for that port; held until the port's next read
//  Mem_Address         out  ADDR_W  to Data_Mem
//  Write_Data          out  DATA_W  to Data_Mem
//  Store_Byte_or_Word  out  1       to Data_Mem (1 byte, 0 word)
//  Mem_Write           out  1       to Data_Mem
//  Mem_Read            out  1       to Data_Mem
//  Read_Data           in   DATA_W  from Data_Mem; valid in the cycle after the Mem_Read cycle
// BEHAVIOUR
//  - Reset: state IDLE; every output and register = 0 (gnt, done, rdata, all Mem_* outputs,
//    starvation count).
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Each access takes 3 cycles; back-to-back accesses
//    start every 3 cycles.
//  - IDLE (cycle T), on an edge where any req is high:
//    - pick the winner and latch its we/byte/addr/wdata;
//    - go to ACCESS.
//  - Winner selection in IDLE:
//    - only one req high -> that port;
//    - both high -> port 0, unless the starvation count equals MAX_WAIT, then port 1.
//  - Starvation count:
//    - +1 on each both-requesting arbitration that port 1 loses;
//    - cleared when port 1 is granted;
//    - saturates at MAX_WAIT.
//  - ACCESS (T+1):
//    - Mem_Address, Write_Data and Store_Byte_or_Word come from the latch;
//    - exactly one of Mem_Write (we=1) or Mem_Read (we=0) is high, for this single cycle;
//    - Data_Mem samples at the end of T+1.
//  - RESP (T+2):
//    - Mem_Write and Mem_Read are 0;
//    - on a read, Read_Data is captured into the winner's rdata, visible from T+3;
//    - the winner's done = 1 for this cycle only.
//  - gnt of the winner is high during T+1..T+2. gnt is never high on both ports, done is
//    never high on both ports, and Mem_Write and Mem_Read are never high together.
//  - The requester drops req when it sees done. req still high in IDLE at T+3 is a new request.
//  - req dropped during ACCESS/RESP is ignored: the transaction completes (the write
//    happens) and done still pulses.
//  - Store_Byte_or_Word is forced to 0 on reads.
//  - Mem_Address and Write_Data hold their last values when idle; only the strobes return to 0.
//  - rst asserted mid-operation: strobes clear immediately (asynchronously), no done is
//    issued, and the FSM restarts in IDLE after rst deasserts.
//  - No address or width arithmetic: addr and byte pass through unchanged; byte-lane
//    handling belongs to Data_Mem.
// STRUCTURE
//  - Shared package/include dmem_arb_pkg: state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1,
//    ST_RESP=2'd2; port index constants PORT0=1'b0, PORT1=1'b1.
//  - One sub-module, dmem_arb_starve_cnt: saturating counter with inc/clr and an
//    at_max flag, parameterised by MAX_WAIT.
//  - Top level holds the FSM, the request latch, the Mem_* output registers and the rdata
//    registers.
// TESTING
//  1 Reset: rst=1 with random inputs -> all outputs 0; after release with no req, Mem_Write
//    and Mem_Read stay 0.
//  2 p0 word write addr=4 wdata=1001 -> at T+1 only: Mem_Write=1, Mem_Address=4,
//    Write_Data=1001, Store_Byte_or_Word=0; p0_done=1 at T+2 only.
//  3 p0 read addr=4 after test 2 -> Mem_Read=1 for one cycle; p0_rdata=1001 from T+3;
//    p1_rdata unchanged.
//  4 p0_req and p1_req held high, MAX_WAIT=4 -> grant sequence p0,p0,p0,p0,p1 repeating;
//    never two grants at once.
//  5 p1 byte write addr=1 wdata=32'hFF while p0 idle -> Store_Byte_or_Word=1 and
//    Mem_Address=1 in ACCESS; p1_done pulses once.
//  6 rst asserted during ACCESS of a write -> Mem_Write=0 immediately, no done;
//    after release with req still high, a fresh 3-cycle access completes.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Mem arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Wide enough for MAX_WAIT in 1..15.
    localparam int CNT_W = 4;

    // Port 0 has priority unless port 1 has been starved long enough.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic starved);
        if (req0 && req1)
            return starved ? PORT1 : PORT0;
        return req1 ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive port-1 losses; at_max forces a port-1 win.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; the count never passes MAX_VAL.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != MAX_VAL))
            r_count <= r_count + CNT_W'(1);
    end

    assign at_max = (r_count == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported Data_Mem.
// Each access runs IDLE -> ACCESS -> RESP; port 0 has priority, port 1 is
// guaranteed progress by the starvation counter.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_byte,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_byte,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Store_Byte_or_Word,
    output logic              Mem_Write,
    output logic              Mem_Read,
    input  logic [DATA_W-1:0] Read_Data
);

    state_t r_state;
    state_t w_next_state;
    logic   w_start;

    logic   r_port;
    logic   r_we;

    logic   w_any_req;
    logic   w_both_req;
    logic   w_at_max;
    logic   w_win;
    logic   w_inc;
    logic   w_clr;

    logic              w_sel_we;
    logic              w_sel_byte;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_any_req  = p0_req | p1_req;
    assign w_both_req = p0_req & p1_req;
    assign w_win      = pick_winner(p0_req, p1_req, w_at_max);

    assign w_sel_we    = (w_win == PORT1) ? p1_we    : p0_we;
    assign w_sel_byte  = (w_win == PORT1) ? p1_byte  : p0_byte;
    assign w_sel_addr  = (w_win == PORT1) ? p1_addr  : p0_addr;
    assign w_sel_wdata = (w_win == PORT1) ? p1_wdata : p0_wdata;

    // Only arbitrations where both ports compete count as a port-1 loss.
    assign w_inc = w_start & w_both_req & (w_win == PORT0);
    assign w_clr = w_start & (w_win == PORT1);

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_inc),
        .clr    (w_clr),
        .at_max (w_at_max)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic; an access starts whenever IDLE sees any request.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ACCESS;
                    w_start      = 1'b1;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, Mem_* drive, grants, done pulses and read capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port             <= PORT0;
            r_we               <= 1'b0;
            Mem_Address        <= '0;
            Write_Data         <= '0;
            Store_Byte_or_Word <= 1'b0;
            Mem_Write          <= 1'b0;
            Mem_Read           <= 1'b0;
            p0_gnt             <= 1'b0;
            p1_gnt             <= 1'b0;
            p0_done            <= 1'b0;
            p1_done            <= 1'b0;
            p0_rdata           <= '0;
            p1_rdata           <= '0;
        end else begin
            // Strobes and done are single-cycle pulses.
            Mem_Write <= 1'b0;
            Mem_Read  <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_port             <= w_win;
                        r_we               <= w_sel_we;
                        Mem_Address        <= w_sel_addr;
                        Write_Data         <= w_sel_wdata;
                        // Byte select is meaningless on reads, so keep it low.
                        Store_Byte_or_Word <= w_sel_we & w_sel_byte;
                        Mem_Write          <= w_sel_we;
                        Mem_Read           <= ~w_sel_we;
                        p0_gnt             <= (w_win == PORT0);
                        p1_gnt             <= (w_win == PORT1);
                    end
                end
                ST_ACCESS: begin
                    p0_done <= (r_port == PORT0);
                    p1_done <= (r_port == PORT1);
                end
                ST_RESP: begin
                    p0_gnt <= 1'b0;
                    p1_gnt <= 1'b0;
                    // Read_Data is valid now, one cycle after the Mem_Read cycle.
                    if (!r_we) begin
                        if (r_port == PORT0)
                            p0_rdata <= Read_Data;
                        else
                            p1_rdata <= Read_Data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// two-port traffic scored against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_byte;
    logic [31:0] p0_addr, p0_wdata;
    logic        p1_req, p1_we, p1_byte;
    logic [31:0] p1_addr, p1_wdata;
    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] Mem_Address, Write_Data;
    logic        Store_Byte_or_Word, Mem_Write, Mem_Read;
    logic [31:0] Read_Data = '0;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: memory contents and port-1 loss streak.
    logic [31:0] ref_mem [logic [31:0]];
    int          losses = 0;

    // Behavioural Data_Mem seen by the DUT.
    logic [31:0] dm [logic [31:0]];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .Mem_Address(Mem_Address), .Write_Data(Write_Data),
        .Store_Byte_or_Word(Store_Byte_or_Word),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
        .Read_Data(Read_Data)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] wd, input logic b);
        return b ? {old_w[31:8], wd[7:0]} : wd;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    // Data_Mem: samples at the end of the strobe cycle, read data next cycle,
    // random garbage on Read_Data whenever no read was issued.
    always @(posedge clk) begin
        if (Mem_Write)
            dm[Mem_Address] = merge(dm.exists(Mem_Address) ? dm[Mem_Address] : 32'd0,
                                    Write_Data, Store_Byte_or_Word);
        if (Mem_Read)
            Read_Data <= dm.exists(Mem_Address) ? dm[Mem_Address] : 32'd0;
        else
            Read_Data <= $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_byte = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_byte = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_req = $urandom; p0_we = $urandom; p0_byte = $urandom;
        p0_addr = $urandom; p0_wdata = $urandom;
        p1_req = $urandom; p1_we = $urandom; p1_byte = $urandom;
        p1_addr = $urandom; p1_wdata = $urandom;
        tick(); tick();
        n_total++;
        if ({p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata, Mem_Address,
             Write_Data, Store_Byte_or_Word, Mem_Write, Mem_Read} !== '0)
            $display("FAIL reset_outputs: gnt=%b%b done=%b%b rd0=%h rd1=%h addr=%h wd=%h sb=%b w=%b r=%b want all 0",
                     p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata,
                     Mem_Address, Write_Data, Store_Byte_or_Word, Mem_Write, Mem_Read);
        else n_pass++;
        idle_inputs();
        rst = 1'b0;
        losses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({Mem_Write, Mem_Read, p0_gnt, p1_gnt} !== 4'b0000)
                $display("FAIL idle_after_reset: w/r/g0/g1=%b want 0000",
                         {Mem_Write, Mem_Read, p0_gnt, p1_gnt});
            else n_pass++;
        end
    endtask

    task automatic test_p0_write();
        p0_req = 1; p0_we = 1; p0_byte = 0; p0_addr = 32'd4; p0_wdata = 32'd1001;
        tick();
        n_total++;
        if ({Mem_Write, Mem_Read, Store_Byte_or_Word, p0_gnt, p1_gnt, p0_done} !== 6'b100100)
            $display("FAIL wr_access_ctl: w/r/sb/g0/g1/d0=%b want 100100",
                     {Mem_Write, Mem_Read, Store_Byte_or_Word, p0_gnt, p1_gnt, p0_done});
        else n_pass++;
        n_total++;
        if (Mem_Address !== 32'd4 || Write_Data !== 32'd1001)
            $display("FAIL wr_access_data: addr=%0d wd=%0d want 4 1001", Mem_Address, Write_Data);
        else n_pass++;
        tick();
        n_total++;
        if ({Mem_Write, Mem_Read, p0_done, p1_done, p0_gnt} !== 5'b00101)
            $display("FAIL wr_resp: w/r/d0/d1/g0=%b want 00101",
                     {Mem_Write, Mem_Read, p0_done, p1_done, p0_gnt});
        else n_pass++;
        p0_req = 0;
        tick();
        n_total++;
        if ({p0_done, p0_gnt, Mem_Write} !== 3'b000 || Mem_Address !== 32'd4)
            $display("FAIL wr_after: d0/g0/w=%b addr=%0d want 000 addr 4",
                     {p0_done, p0_gnt, Mem_Write}, Mem_Address);
        else n_pass++;
        ref_mem[32'd4] = 32'd1001;
    endtask

    task automatic test_p0_read();
        logic [31:0] p1_prev;
        p1_prev = p1_rdata;
        // byte=1 on a read must not reach Store_Byte_or_Word.
        p0_req = 1; p0_we = 0; p0_byte = 1; p0_addr = 32'd4;
        tick();
        n_total++;
        if ({Mem_Read, Mem_Write, Store_Byte_or_Word} !== 3'b100 || Mem_Address !== 32'd4)
            $display("FAIL rd_access: r/w/sb=%b addr=%0d want 100 addr 4",
                     {Mem_Read, Mem_Write, Store_Byte_or_Word}, Mem_Address);
        else n_pass++;
        tick();
        n_total++;
        if ({Mem_Read, p0_done} !== 2'b01)
            $display("FAIL rd_resp: r/d0=%b want 01", {Mem_Read, p0_done});
        else n_pass++;
        p0_req = 0;
        tick();
        n_total++;
        if (p0_rdata !== ref_rd(32'd4) || p1_rdata !== p1_prev)
            $display("FAIL rd_data: p0_rdata=%0d p1_rdata=%h want %0d %h",
                     p0_rdata, p1_rdata, ref_rd(32'd4), p1_prev);
        else n_pass++;
        p0_byte = 0;
    endtask

    task automatic test_fairness();
        int seen = 0;
        int cyc  = 0;
        logic exp_p1;
        p0_req = 1; p0_we = 0; p0_addr = 32'd0;
        p1_req = 1; p1_we = 0; p1_addr = 32'd4;
        while (seen < 10 && cyc < 40) begin
            tick();
            cyc++;
            n_total++;
            if ((p0_gnt & p1_gnt) | (p0_done & p1_done) | (Mem_Write & Mem_Read))
                $display("FAIL fair_exclusive: g=%b%b d=%b%b w/r=%b%b at cycle %0d",
                         p0_gnt, p1_gnt, p0_done, p1_done, Mem_Write, Mem_Read, cyc);
            else n_pass++;
            if (p0_done | p1_done) begin
                exp_p1 = (losses == MAX_WAIT);
                if (exp_p1) losses = 0;
                else if (losses < MAX_WAIT) losses++;
                n_total++;
                if (p1_done !== exp_p1)
                    $display("FAIL fair_grant%0d: p1_done=%b want %b", seen, p1_done, exp_p1);
                else n_pass++;
                seen++;
            end
        end
        n_total++;
        if (seen != 10) $display("FAIL fair_timeout: dones=%0d want 10", seen);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_p1_byte();
        int ndone = 0;
        p1_req = 1; p1_we = 1; p1_byte = 1; p1_addr = 32'd1; p1_wdata = 32'hFF;
        tick();
        n_total++;
        if ({Store_Byte_or_Word, Mem_Write, p1_gnt, p0_gnt} !== 4'b1110 || Mem_Address !== 32'd1)
            $display("FAIL p1_byte_access: sb/w/g1/g0=%b addr=%0d want 1110 addr 1",
                     {Store_Byte_or_Word, Mem_Write, p1_gnt, p0_gnt}, Mem_Address);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (p1_done) begin ndone++; p1_req = 0; end
        end
        n_total++;
        if (ndone != 1) $display("FAIL p1_byte_done: pulses=%0d want 1", ndone);
        else n_pass++;
        ref_mem[32'd1] = merge(ref_rd(32'd1), 32'hFF, 1'b1);
        losses = 0;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        int k = 0;
        bit got = 0;
        wd = $urandom;
        p0_req = 1; p0_we = 1; p0_byte = 0; p0_addr = 32'd8; p0_wdata = wd;
        tick();
        n_total++;
        if (Mem_Write !== 1'b1) $display("FAIL mid_pre: Mem_Write=%b want 1", Mem_Write);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({Mem_Write, p0_gnt} !== 2'b00)
            $display("FAIL mid_async_clear: w/g0=%b want 00", {Mem_Write, p0_gnt});
        else n_pass++;
        tick();
        n_total++;
        if ({p0_done, p1_done} !== 2'b00)
            $display("FAIL mid_no_done: d0/d1=%b want 00", {p0_done, p1_done});
        else n_pass++;
        rst = 1'b0;
        losses = 0;
        while (!got && k < 8) begin
            tick();
            k++;
            if (Mem_Write) begin
                n_total++;
                if (Mem_Address !== 32'd8 || Write_Data !== wd)
                    $display("FAIL mid_retry_access: addr=%0d wd=%h want 8 %h", Mem_Address, Write_Data, wd);
                else n_pass++;
            end
            if (p0_done) got = 1;
        end
        n_total++;
        if (!got || k != 2) $display("FAIL mid_retry_done: done=%0b cycle=%0d want 1 at 2", got, k);
        else n_pass++;
        idle_inputs();
        tick();
        ref_mem[32'd8] = wd;
    endtask

    task automatic test_random();
        logic        r0, r1, w, exp_we, exp_byte;
        logic [31:0] exp_addr, exp_wdata, got_rd;
        logic [31:0] addrs [4];
        int k;
        bit got;
        addrs[0] = 32'd0; addrs[1] = 32'd1; addrs[2] = 32'd4; addrs[3] = 32'd8;
        for (int n = 0; n < 40; n++) begin
            r0 = $urandom; r1 = $urandom;
            if (!r0 && !r1) r0 = 1;
            p0_req = r0; p0_we = $urandom; p0_byte = $urandom;
            p0_addr = addrs[$urandom_range(0, 3)]; p0_wdata = $urandom;
            p1_req = r1; p1_we = $urandom; p1_byte = $urandom;
            p1_addr = addrs[$urandom_range(0, 3)]; p1_wdata = $urandom;
            if (r0 && r1) begin
                w = (losses == MAX_WAIT);
                if (w) losses = 0; else if (losses < MAX_WAIT) losses++;
            end else begin
                w = r1;
                if (r1) losses = 0;
            end
            exp_we    = w ? p1_we    : p0_we;
            exp_byte  = w ? p1_byte  : p0_byte;
            exp_addr  = w ? p1_addr  : p0_addr;
            exp_wdata = w ? p1_wdata : p0_wdata;
            k = 0; got = 0;
            while (!got && k < 8) begin
                tick();
                k++;
                if (Mem_Write | Mem_Read) begin
                    n_total++;
                    if (Mem_Write !== exp_we || Mem_Read !== !exp_we || Mem_Address !== exp_addr ||
                        Store_Byte_or_Word !== (exp_we & exp_byte) || (exp_we && Write_Data !== exp_wdata))
                        $display("FAIL rnd%0d_access: w/r/sb=%b%b%b addr=%0d wd=%h want %b%b%b addr=%0d wd=%h",
                                 n, Mem_Write, Mem_Read, Store_Byte_or_Word, Mem_Address, Write_Data,
                                 exp_we, !exp_we, exp_we & exp_byte, exp_addr, exp_wdata);
                    else n_pass++;
                end
                if (p0_done | p1_done) begin
                    got = 1;
                    n_total++;
                    if ({p1_done, p0_done} !== {w, !w} || k != 2)
                        $display("FAIL rnd%0d_done: d1/d0=%b%b cycle=%0d want %b%b at 2",
                                 n, p1_done, p0_done, k, w, !w);
                    else n_pass++;
                end
            end
            if (!got) begin
                n_total++;
                $display("FAIL rnd%0d_timeout: no done within 8 cycles", n);
            end
            idle_inputs();
            tick();
            if (exp_we) begin
                ref_mem[exp_addr] = merge(ref_rd(exp_addr), exp_wdata, exp_byte);
            end else begin
                got_rd = w ? p1_rdata : p0_rdata;
                n_total++;
                if (got_rd !== ref_rd(exp_addr))
                    $display("FAIL rnd%0d_rdata: port%0d rdata=%h want %h", n, w, got_rd, ref_rd(exp_addr));
                else n_pass++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_p0_write();
        test_p0_read();
        test_fairness();
        test_p1_byte();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
